// File: rtl/stage_writeback_pipe.sv
// Writeback stage: registers the MEM/WB payload, selects ALU / load / PC+4 result,
// extends load data, gates x0 writes and counts retired instructions.
module stage_writeback_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wr_enable,
    input  logic [1:0]            mem_result_sel,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_read_data,
    input  logic [XLEN-1:0]       mem_instr_addr_plus,
    input  logic                  wb_stall,
    input  logic                  wb_flush,
    output logic                  mem_ready,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_wr_enable,
    output logic [XLEN-1:0]       wb_write_data,
    output logic [XLEN-1:0]       wb_next_instr_addr,
    output logic [63:0]           wb_instret
);

    localparam int OFS_W = $clog2(XLEN / 8);

    logic [OFS_W-1:0] ofs;
    logic [OFS_W-1:0] ofs_half;
    logic [OFS_W-1:0] ofs_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_word;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  result;
    logic             wb_we_q;

    assign mem_ready = !wb_stall | wb_flush;

    // Clearing the low offset bits aligns halves/words; misalignment is silently ignored.
    assign ofs      = mem_alu_result[OFS_W-1:0];
    assign ofs_half = ofs & ~OFS_W'(1);
    assign ofs_word = ofs & ~OFS_W'(3);

    always_comb begin
        ld_byte = 8'(mem_read_data >> {ofs, 3'b000});
        ld_half = 16'(mem_read_data >> {ofs_half, 3'b000});
        ld_word = 32'(mem_read_data >> {ofs_word, 3'b000});
        case (mem_funct3)
            3'b000:  load_data = XLEN'($signed(ld_byte));
            3'b100:  load_data = XLEN'(ld_byte);
            3'b001:  load_data = XLEN'($signed(ld_half));
            3'b101:  load_data = XLEN'(ld_half);
            3'b010:  load_data = XLEN'($signed(ld_word));
            3'b110:  load_data = (XLEN == 64) ? XLEN'(ld_word) : mem_read_data;
            // LD, reserved codes and 64-bit-only codes on XLEN=32 all pass the word through
            default: load_data = mem_read_data;
        endcase
    end

    always_comb begin
        case (mem_result_sel)
            2'b00:   result = mem_alu_result;
            2'b01:   result = load_data;
            2'b10:   result = mem_instr_addr_plus;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid           <= 1'b0;
            wb_rd              <= '0;
            wb_we_q            <= 1'b0;
            wb_write_data      <= '0;
            wb_next_instr_addr <= '0;
            wb_instret         <= '0;
        end else if (wb_flush) begin
            wb_valid           <= 1'b0;
            wb_rd              <= '0;
            wb_we_q            <= 1'b0;
            wb_write_data      <= '0;
            wb_next_instr_addr <= '0;
        end else if (!wb_stall) begin
            wb_valid           <= mem_valid;
            wb_rd              <= mem_rd;
            wb_we_q            <= mem_wr_enable;
            wb_write_data      <= result;
            wb_next_instr_addr <= mem_instr_addr_plus;
            if (mem_valid) begin
                wb_instret <= wb_instret + 64'd1;
            end
        end
    end

    assign wb_wr_enable = wb_valid & wb_we_q & (wb_rd != '0);

endmodule
